accel_poll_sequencer: RTL and testbench

//  Sequences the single-transaction I2C controller to bring up the ADXL345 accelerometer (0x1D).

---
 rtl/accel_seq_pkg.sv | 41 ++++
 rtl/accel_poll_sequencer_rate_tick.sv | 31 +++
 rtl/accel_poll_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_accel_poll_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_seq_pkg.sv
// Shared definitions for the ADXL345 bring-up and poll sequencer.
// Holds the FSM state encodings, ADXL345 register map subset and init ROM.
// No logic; imported by the sequencer and its sub-modules.
package accel_seq_pkg;

  // FSM state encodings, kept as plain constants so debug tooling can decode dbg_state
  typedef logic [3:0] seq_state_e;
  localparam seq_state_e ST_INIT_ISSUE = 4'd0;
  localparam seq_state_e ST_INIT_WAIT  = 4'd1;
  localparam seq_state_e ST_POLL_WAIT  = 4'd2;
  localparam seq_state_e ST_RD_ISSUE   = 4'd3;
  localparam seq_state_e ST_RD_WAIT    = 4'd4;
  localparam seq_state_e ST_PUBLISH    = 4'd5;
  localparam seq_state_e ST_ERROR      = 4'd6;

  // ADXL345 registers used by the sequencer
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_BW_RATE     = 8'h2C;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  localparam int INIT_ROWS  = 3;
  localparam int DATA_BYTES = 6;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } init_row_t;

  // Init ROM, row 0 in the low 16 bits: measure mode, full-res +/-2g, 100 Hz output rate
  localparam logic [INIT_ROWS*16-1:0] INIT_ROM = {
    REG_BW_RATE,     8'h0A,
    REG_DATA_FORMAT, 8'h08,
    REG_POWER_CTL,   8'h08
  };

  function automatic init_row_t init_row(input logic [1:0] idx);
    init_row = init_row_t'(INIT_ROM[int'(idx)*16 +: 16]);
  endfunction

endpackage

// File: rtl/accel_poll_sequencer_rate_tick.sv
// Free-running sample-rate divider producing a one-cycle tick every period.
// Tick is registered: asserted the cycle after the counter reaches period-1.
// No backpressure; an unconsumed tick is simply lost.
module accel_rate_tick #(
  parameter int SYS_CLK_SPEED  = 50000000,
  parameter int SAMPLE_RATE_HZ = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PERIOD = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  // count 0..PERIOD-1 and flag the wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/accel_poll_sequencer.sv
// Brings up the ADXL345 with three config writes, then polls six data bytes per rate tick.
// Optional watchdog via `ACCEL_SEQ_TIMEOUT_EN (aborts a hung transaction, pulses i2c_rst).
// Sole requester of the I2C controller; waits on i2c_ready before every start pulse.
module accel_poll_sequencer
  import accel_seq_pkg::*;
#(
  parameter int         SYS_CLK_SPEED  = 50000000,
  parameter int         SAMPLE_RATE_HZ = 100,
  parameter logic [6:0] DEV_ADDR       = 7'h1D
`ifdef ACCEL_SEQ_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [6:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic        i2c_r_w,
  output logic [7:0]  i2c_write_data,
  input  logic [7:0]  i2c_read_data,
  output logic        i2c_start,
  input  logic        i2c_finished,
  input  logic        i2c_ready,
  output logic        i2c_rst,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        seq_error,
  output logic [3:0]  dbg_state
);

  seq_state_e       state;
  logic [1:0]       row;
  logic [2:0]       byte_idx;
  logic             accepted;
  logic [5:0][7:0]  shadow;
  logic             tick;
  logic             done;
  logic             issue_fire;
  logic             timeout;
  init_row_t        rom_row;

  accel_rate_tick #(
    .SYS_CLK_SPEED  (SYS_CLK_SPEED),
    .SAMPLE_RATE_HZ (SAMPLE_RATE_HZ)
  ) u_rate_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign i2c_dev_addr = DEV_ADDR;
  assign dbg_state    = state;
  assign rom_row      = init_row(row);

  // The finished flag is stale until the controller has visibly gone busy for this request
  assign done = accepted & i2c_ready & i2c_finished;

  assign issue_fire = ((state == ST_INIT_ISSUE) && enable && i2c_ready) ||
                      ((state == ST_RD_ISSUE) && i2c_ready);

`ifdef ACCEL_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd_cnt;
  logic           in_wait;

  assign in_wait = (state == ST_INIT_WAIT) || (state == ST_RD_WAIT);
  assign timeout = in_wait && (wd_cnt == WD_LAST);

  // watchdog: zero during the start cycle, one count per cycle spent waiting
  always_ff @(posedge clk) begin
    if (rst)             wd_cnt <= '0;
    else if (issue_fire) wd_cnt <= '0;
    else if (in_wait)    wd_cnt <= wd_cnt + WDW'(1);
  end

  // abort: one-cycle controller reset and a sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      i2c_rst   <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      i2c_rst <= timeout;
      if (timeout) seq_error <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign i2c_rst   = 1'b0;
  assign seq_error = 1'b0;
`endif

  // main sequencer: request generation, completion tracking, sample assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_INIT_ISSUE;
      row            <= '0;
      byte_idx       <= '0;
      accepted       <= 1'b0;
      shadow         <= '0;
      i2c_reg_addr   <= '0;
      i2c_r_w        <= 1'b0;
      i2c_write_data <= '0;
      i2c_start      <= 1'b0;
      accel_x        <= '0;
      accel_y        <= '0;
      accel_z        <= '0;
      sample_valid   <= 1'b0;
      init_done      <= 1'b0;
    end else begin
      i2c_start    <= 1'b0;
      sample_valid <= 1'b0;
      if (timeout) begin
        state <= ST_ERROR;
      end else begin
        case (state)
          ST_INIT_ISSUE: begin
            if (issue_fire) begin
              i2c_reg_addr   <= rom_row.reg_addr;
              i2c_write_data <= rom_row.data;
              i2c_r_w        <= 1'b0;
              i2c_start      <= 1'b1;
              accepted       <= 1'b0;
              state          <= ST_INIT_WAIT;
            end
          end
          ST_INIT_WAIT: begin
            if (!i2c_ready) accepted <= 1'b1;
            if (done) begin
              if (row == 2'(INIT_ROWS - 1)) begin
                init_done <= 1'b1;
                state     <= ST_POLL_WAIT;
              end else begin
                row   <= row + 2'd1;
                state <= ST_INIT_ISSUE;
              end
            end
          end
          ST_POLL_WAIT: begin
            if (tick && enable) begin
              byte_idx <= '0;
              state    <= ST_RD_ISSUE;
            end
          end
          ST_RD_ISSUE: begin
            if (issue_fire) begin
              i2c_reg_addr   <= REG_DATAX0 + {5'd0, byte_idx};
              i2c_write_data <= '0;
              i2c_r_w        <= 1'b1;
              i2c_start      <= 1'b1;
              accepted       <= 1'b0;
              state          <= ST_RD_WAIT;
            end
          end
          ST_RD_WAIT: begin
            if (!i2c_ready) accepted <= 1'b1;
            if (done) begin
              shadow[byte_idx] <= i2c_read_data;
              if (byte_idx == 3'(DATA_BYTES - 1)) begin
                state <= ST_PUBLISH;
              end else begin
                byte_idx <= byte_idx + 3'd1;
                state    <= ST_RD_ISSUE;
              end
            end
          end
          ST_PUBLISH: begin
            accel_x      <= {shadow[1], shadow[0]};
            accel_y      <= {shadow[3], shadow[2]};
            accel_z      <= {shadow[5], shadow[4]};
            sample_valid <= 1'b1;
            state        <= ST_POLL_WAIT;
          end
          ST_ERROR: begin
            state <= ST_ERROR;
          end
          default: begin
            state <= ST_INIT_ISSUE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Self-checking bench for accel_poll_sequencer with a behavioural I2C controller model.
// Build with `ACCEL_SEQ_TIMEOUT_EN to also exercise the watchdog abort path.
module tb_accel_poll_sequencer;
  import accel_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable;
  logic [6:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr, i2c_write_data, i2c_read_data;
  logic        i2c_r_w, i2c_start, i2c_finished, i2c_ready, i2c_rst;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, init_done, seq_error;
  logic [3:0]  dbg_state;

  accel_poll_sequencer #(
    .SYS_CLK_SPEED  (1000),
    .SAMPLE_RATE_HZ (10),
    .DEV_ADDR       (7'h1D)
`ifdef ACCEL_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES (50)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .i2c_dev_addr   (i2c_dev_addr),
    .i2c_reg_addr   (i2c_reg_addr),
    .i2c_r_w        (i2c_r_w),
    .i2c_write_data (i2c_write_data),
    .i2c_read_data  (i2c_read_data),
    .i2c_start      (i2c_start),
    .i2c_finished   (i2c_finished),
    .i2c_ready      (i2c_ready),
    .i2c_rst        (i2c_rst),
    .accel_x        (accel_x),
    .accel_y        (accel_y),
    .accel_z        (accel_z),
    .sample_valid   (sample_valid),
    .init_done      (init_done),
    .seq_error      (seq_error),
    .dbg_state      (dbg_state)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2, b3, b4, b5;
    logic [15:0] x, y, z;
  } vec_t;
  vec_t vecs[4];

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboards
  logic [15:0] exp_wr[$];   // {reg, data} for each expected config write
  logic [47:0] samp_q[$];   // {x, y, z} for each expected sample

  // controller model state
  logic [7:0] mem[6];
  int         lat = 20;
  bit         hang = 1'b0;
  int         cnt = 0;
  int         rd_idx = 0;
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         rst_pulses = 0;
  int         cyc = 0;
  logic [7:0] cap_reg;
  logic       cap_rw;
  logic [47:0] e;
  int         idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // controller model and output monitor, evaluated away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      i2c_ready    = 1'b1;
      i2c_finished = 1'b0;
      cnt          = 0;
      rd_idx       = 0;
    end else begin
      if (i2c_rst) begin
        rst_pulses++;
        i2c_ready    = 1'b1;
        i2c_finished = 1'b0;
        cnt          = 0;
      end
      if (i2c_start) begin
        start_cnt++;
        start_cyc = cyc;
        check("start_while_ready", i2c_ready, 1);
        check("dev_addr", i2c_dev_addr, 7'h1D);
        cap_reg = i2c_reg_addr;
        cap_rw  = i2c_r_w;
        if (!i2c_r_w) begin
          if (exp_wr.size() == 0) begin
            check("unexpected_write", 1'b1, 1'b0);
          end else begin
            e = {32'd0, exp_wr.pop_front()};
            check("wr_reg", i2c_reg_addr, e[15:8]);
            check("wr_data", i2c_write_data, e[7:0]);
          end
        end else begin
          check("rd_reg", i2c_reg_addr, 8'h32 + 8'(rd_idx));
          rd_idx = (rd_idx == 5) ? 0 : rd_idx + 1;
        end
        i2c_ready    = 1'b0;
        i2c_finished = 1'b0;
        cnt          = lat;
      end else if (cnt > 0 && !hang) begin
        cnt--;
        if (cnt == 0) begin
          check("req_stable", {i2c_reg_addr, i2c_r_w}, {cap_reg, cap_rw});
          idx = int'(cap_reg) - 'h32;
          if (cap_rw && idx >= 0 && idx < 6) i2c_read_data = mem[idx];
          i2c_ready    = 1'b1;
          i2c_finished = 1'b1;
        end
      end
      if (sample_valid) begin
        if (samp_q.size() == 0) begin
          check("unexpected_sample", sample_valid, 1'b0);
        end else begin
          e = samp_q.pop_front();
          check("sample_x", accel_x, e[47:32]);
          check("sample_y", accel_y, e[31:16]);
          check("sample_z", accel_z, e[15:0]);
        end
      end
    end
  end

  task automatic set_mem(input vec_t v);
    mem[0] = v.b0; mem[1] = v.b1; mem[2] = v.b2;
    mem[3] = v.b3; mem[4] = v.b4; mem[5] = v.b5;
  endtask

  task automatic wait_sample(output int c);
    int k = 0;
    @(negedge clk);
    while (!sample_valid && k < 600) begin @(negedge clk); k++; end
    check("wait_sample", sample_valid, 1'b1);
    c = cyc;
  endtask

  task automatic wait_init();
    int k = 0;
    while (!init_done && k < 1000) begin @(negedge clk); k++; end
    check("wait_init_done", init_done, 1'b1);
  endtask

  task automatic wait_state(input logic [3:0] s);
    int k = 0;
    while (dbg_state != s && k < 600) begin @(negedge clk); k++; end
    check("wait_state", dbg_state, s);
  endtask

  task automatic wait_rd(input logic [7:0] r);
    int k = 0;
    while (!(dbg_state == ST_RD_WAIT && i2c_reg_addr == r) && k < 600) begin
      @(negedge clk); k++;
    end
    check("wait_rd_wait", {dbg_state, i2c_reg_addr}, {ST_RD_WAIT, r});
  endtask

  task automatic push_init();
    exp_wr.push_back(16'h2D08);
    exp_wr.push_back(16'h3108);
    exp_wr.push_back(16'h2C0A);
  endtask

  initial begin
    int c1, c2, c3, c4, c5, base, snap;
    logic [47:0] prev;

    vecs[0] = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h80, 16'h1234, 16'hFFFE, 16'h8000};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{8'hFF, 8'h7F, 8'h01, 8'h00, 8'h55, 8'hAA, 16'h7FFF, 16'h0001, 16'hAA55};
    vecs[3] = '{8'h00, 8'h80, 8'hFF, 8'hFF, 8'hCD, 8'hAB, 16'h8000, 16'hFFFF, 16'hABCD};

    rst = 1'b1; enable = 1'b0;
    i2c_ready = 1'b1; i2c_finished = 1'b0; i2c_read_data = 8'h00;
    set_mem(vecs[0]);
    repeat (3) @(negedge clk);

    // reset state
    check("rst_start", i2c_start, 1'b0);
    check("rst_req", {i2c_reg_addr, i2c_write_data, i2c_r_w}, 17'd0);
    check("rst_accel", {accel_x, accel_y, accel_z}, 48'd0);
    check("rst_flags", {sample_valid, init_done, seq_error, i2c_rst}, 4'd0);
    check("rst_state", dbg_state, ST_INIT_ISSUE);
    check("rst_dev_addr", i2c_dev_addr, 7'h1D);

    // init: three writes in ROM order
    push_init();
    base = start_cnt;
    rst = 1'b0; enable = 1'b1;
    wait_init();
    check("init_writes", start_cnt - base, 3);
    check("init_wr_q_empty", exp_wr.size(), 0);
    check("init_to_poll_wait", dbg_state, ST_POLL_WAIT);

    // table-driven polls: outputs hold the previous sample until publish
    lat = 5;
    prev = 48'd0;
    for (int i = 0; i < 4; i++) begin
      set_mem(vecs[i]);
      samp_q.push_back({vecs[i].x, vecs[i].y, vecs[i].z});
      wait_state(ST_PUBLISH);
      check("accel_hold", {accel_x, accel_y, accel_z}, prev);
      wait_sample(c1);
      prev = {vecs[i].x, vecs[i].y, vecs[i].z};
    end

    // rate: short polls track every tick, long polls drop every other tick
    samp_q.push_back(prev); wait_sample(c1);
    samp_q.push_back(prev); wait_sample(c2);
    check("spacing_100", c2 - c1, 100);
    lat = 22;
    samp_q.push_back(prev); wait_sample(c3);
    samp_q.push_back(prev); wait_sample(c4);
    check("spacing_200_a", c4 - c3, 200);
    samp_q.push_back(prev); wait_sample(c5);
    check("spacing_200_b", c5 - c4, 200);

    // enable dropped mid-poll: poll completes, then no more requests
    lat = 5;
    set_mem(vecs[2]);
    samp_q.push_back({vecs[2].x, vecs[2].y, vecs[2].z});
    wait_rd(8'h34);
    enable = 1'b0;
    wait_sample(c1);
    check("all_bytes_read", rd_idx, 0);
    snap = start_cnt;
    repeat (300) @(negedge clk);
    check("no_start_disabled", start_cnt, snap);
    check("hold_poll_wait", dbg_state, ST_POLL_WAIT);

    // reset mid-transaction at byte 4
    enable = 1'b1;
    wait_rd(8'h36);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_accel", {accel_x, accel_y, accel_z}, 48'd0);
    check("midrst_req", {i2c_start, i2c_r_w, i2c_reg_addr, i2c_write_data}, 18'd0);
    check("midrst_flags", {sample_valid, init_done, seq_error, i2c_rst}, 4'd0);
    check("midrst_state", dbg_state, ST_INIT_ISSUE);
    push_init();
    base = start_cnt;
    lat = 20;
    rst = 1'b0;
    wait_init();
    check("reinit_writes", start_cnt - base, 3);
    check("reinit_wr_q_empty", exp_wr.size(), 0);

`ifdef ACCEL_SEQ_TIMEOUT_EN
    check("no_early_abort", rst_pulses, 0);
    hang = 1'b1;
    begin
      int k = 0;
      while (!i2c_rst && k < 600) begin @(negedge clk); k++; end
      check("wd_i2c_rst", i2c_rst, 1'b1);
      check("wd_delay", cyc - start_cyc, 50);
    end
    @(negedge clk);
    check("wd_rst_one_cycle", i2c_rst, 1'b0);
    check("wd_seq_error", seq_error, 1'b1);
    check("wd_state", dbg_state, ST_ERROR);
    snap = start_cnt;
    repeat (200) @(negedge clk);
    check("wd_no_start", start_cnt, snap);
    check("wd_error_sticky", seq_error, 1'b1);
`else
    check("no_i2c_rst", rst_pulses, 0);
    check("no_seq_error", seq_error, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
